// File: rtl/rr_burst_mux_pkg.sv
// Shared types and helpers for the round-robin burst mux and other arbiter consumers.
package rr_burst_mux_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Index of the (single) set bit; 0 when no bit is set.
  function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // True only for exactly one bit set in a 3-bit vector.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/rr_out_slice.sv
// One-entry registered valid/ready output stage carrying data, last flag and source tag.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   in_valid_i       upstream beat valid; loaded when in_ready_c_o is high
//   in_data_i/last/src  beat payload
//   in_ready_c_o     combinational: slot empty or draining this cycle
//   out_valid_o/data/last/src  registered output beat
//   out_ready_i      downstream accept
module rr_out_slice
  import rr_burst_mux_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid_i,
  input  logic [DW-1:0]   in_data_i,
  input  logic            in_last_i,
  input  logic [CH_W-1:0] in_src_i,
  output logic            in_ready_c_o,
  output logic            out_valid_o,
  output logic [DW-1:0]   out_data_o,
  output logic            out_last_o,
  output logic [CH_W-1:0] out_src_o,
  input  logic            out_ready_i
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;
  logic [CH_W-1:0] src_q, src_d;
  logic            load;

  assign in_ready_c_o = ~valid_q | out_ready_i;
  assign load         = in_valid_i & in_ready_c_o;

  // Load has priority over drain so back-to-back beats keep valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    src_d   = src_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      last_d  = in_last_i;
      src_d   = in_src_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      src_q   <= src_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_src_o   = src_q;

endmodule

// File: rtl/rr_burst_mux.sv
// Burst-locking 3:1 mux behind a round-robin arbiter with a registered output stage.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   s_valid/s_last/s_data  per-channel beats (channel i data at [i*DW +: DW])
//   s_ready       per-channel accept (only the locked channel, only in XFER)
//   arb_req       request vector to the arbiter (s_valid while idle, 0 while locked)
//   arb_grant     one-hot grant, combinational reply to arb_req
//   arb_en        arbiter priority-update strobe, one cycle per accepted grant
//   m_valid/m_data/m_last/m_src/m_ready  registered output stream
//   busy          a burst is locked
//   err_len       sticky: some burst exceeded MAX_BEATS beats
module rr_burst_mux
  import rr_burst_mux_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_CH-1:0]    s_valid,
  input  logic [NUM_CH-1:0]    s_last,
  input  logic [NUM_CH*DW-1:0] s_data,
  output logic [NUM_CH-1:0]    s_ready,
  output logic [NUM_CH-1:0]    arb_req,
  input  logic [NUM_CH-1:0]    arb_grant,
  output logic                 arb_en,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  output logic                 m_last,
  output logic [CH_W-1:0]      m_src,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err_len
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            sel_valid, sel_last;
  logic [DW-1:0]   sel_data;
  logic            slot_ready;
  logic            acc_valid;

  // Select the locked channel's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_q == CH_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DW +: DW];
      end
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    arb_req   = '0;
    arb_en    = 1'b0;
    s_ready   = '0;
    busy      = 1'b0;
    acc_valid = 1'b0;
    case (state_q)
      IDLE: begin
        arb_req = s_valid;
        // Only a clean one-hot grant to a requesting channel starts a burst.
        if (is_onehot3(arb_grant) && |(arb_grant & s_valid)) begin
          arb_en  = 1'b1;
          sel_d   = onehot_to_idx(arb_grant);
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (sel_q == CH_W'(i)) s_ready[i] = slot_ready;
        end
        acc_valid = sel_valid & slot_ready;
        if (acc_valid) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          // Accepting a beat with MAX_BEATS already counted means the burst overran.
          if (cnt_q == CNT_MAX) err_d = 1'b1;
          if (sel_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  rr_out_slice #(
    .DW(DW)
  ) u_out_slice (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid_i   (acc_valid),
    .in_data_i    (sel_data),
    .in_last_i    (sel_last),
    .in_src_i     (sel_q),
    .in_ready_c_o (slot_ready),
    .out_valid_o  (m_valid),
    .out_data_o   (m_data),
    .out_last_o   (m_last),
    .out_src_o    (m_src),
    .out_ready_i  (m_ready)
  );

  assign err_len = err_q;

endmodule
